oam_dma: RTL and testbench

Sprite DMA engine for the 2A03 bus, directly downstream of the CPU core. It snoops CPU write cycles for a write to $4014 and then halts the core through the core's ready input. It then copies one 256-byte page to the PPU OAM data port ($2004) as alternating read/write bus cycles. While active, it owns the address/data bus through a mux select, and it returns the bus and releases ready when the copy is complete.

---
 rtl/dma_pkg.sv | 32 +++
 rtl/oam_dma.sv | 178 +++++++++++++++++
 tb/tb_oam_dma.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Package : dma_pkg
// Purpose : Shared types and constants for the OAM sprite DMA engine.
//           Holds the FSM state encoding, the get/put parity type and the
//           default bus addresses used as parameter defaults by oam_dma.
// Rev     : 1.0  initial release
// ============================================================================
package dma_pkg;

   // CPU register that starts a sprite transfer when written.
   localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
   // PPU OAM data port; destination of every write cycle.
   localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

   // Transfer sequencer states (explicit 3-bit encoding).
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_GET   = 3'd3,
      ST_PUT   = 3'd4
   } dma_state_type;

   // Parity of the current CPU cycle: get (read) or put (write) slot.
   typedef enum bit {
      PH_GET = 1'b0,
      PH_PUT = 1'b1
   } dma_parity_type;

endpackage
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module  : oam_dma
// Purpose : Sprite DMA engine for the 2A03 bus. Snoops core writes for the
//           DMA trigger register, freezes the core through its ready input,
//           then copies one 256-byte page to the PPU OAM data port as
//           alternating read / write bus cycles.
// Ports   :
//   I_clock        in   1   system clock (rising edge)
//   I_reset        in   1   asynchronous reset, active low
//   I_cycle        in   1   strobe on the last clock of every CPU cycle
//   I_cpu_addr     in  16   core address bus
//   I_cpu_wr_data  in   8   core write data
//   I_cpu_rdwr     in   1   core direction, 1 = read
//   I_rd_data      in   8   shared read data bus
//   O_ready        out  1   core ready; 0 freezes the core
//   O_bus_own      out  1   1 = bus mux selects the DMA address/data/dir
//   O_addr         out 16   DMA address
//   O_wr_data      out  8   DMA write data
//   O_rdwr         out  1   DMA direction, 1 = read
//   O_busy         out  1   1 whenever a transfer is in progress
// Rev     : 1.0  initial release
// ============================================================================
module oam_dma
   import dma_pkg::*;
#(
   parameter logic [15:0] P_DMA_REG  = DMA_REG_ADDR,
   parameter logic [15:0] P_OAM_PORT = OAM_DATA_ADDR
) (
   input  logic        I_clock,
   input  logic        I_reset,
   input  logic        I_cycle,
   input  logic [15:0] I_cpu_addr,
   input  logic [7:0]  I_cpu_wr_data,
   input  logic        I_cpu_rdwr,
   input  logic [7:0]  I_rd_data,
   output logic        O_ready,
   output logic        O_bus_own,
   output logic [15:0] O_addr,
   output logic [7:0]  O_wr_data,
   output logic        O_rdwr,
   output logic        O_busy
);

   dma_state_type  state_q,     state_d;
   dma_parity_type put_phase_q, put_phase_d;
   logic [7:0]     page_q,      page_d;
   logic [7:0]     count_q,     count_d;
   logic [7:0]     data_q,      data_d;

   logic           trigger_hit;

   // A core write to the trigger register. Reads never start a transfer.
   assign trigger_hit = (I_cpu_addr == P_DMA_REG) && !I_cpu_rdwr;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         state_q     <= ST_IDLE;
         put_phase_q <= PH_GET;
         page_q      <= 8'h00;
         count_q     <= 8'h00;
         data_q      <= 8'h00;
      end else begin
         state_q     <= state_d;
         put_phase_q <= put_phase_d;
         page_q      <= page_d;
         count_q     <= count_d;
         data_q      <= data_d;
      end
   end

   // ------------------------------------------------------------------
   // Next state. Everything advances only on the CPU-cycle strobe, so
   // the engine freezes cleanly if the timing divider stalls.
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      put_phase_d = put_phase_q;
      page_d      = page_q;
      count_d     = count_q;
      data_d      = data_q;

      if (I_cycle) begin
         // Free-running get/put parity, independent of the FSM.
         put_phase_d = (put_phase_q == PH_GET) ? PH_PUT : PH_GET;

         case (state_q)
            ST_IDLE: begin
               if (trigger_hit) begin
                  page_d  = I_cpu_wr_data;
                  count_d = 8'h00;
                  state_d = ST_HALT;
               end
            end

            // The first read must land on a get slot. If the halt cycle
            // is a put slot the next cycle is already a get slot;
            // otherwise one alignment cycle is burnt.
            ST_HALT: begin
               state_d = (put_phase_q == PH_PUT) ? ST_GET : ST_ALIGN;
            end

            ST_ALIGN: begin
               state_d = ST_GET;
            end

            ST_GET: begin
               data_d  = I_rd_data;
               state_d = ST_PUT;
            end

            // count wraps inside the page; it never carries into page_q.
            ST_PUT: begin
               if (count_q == 8'hFF) begin
                  state_d = ST_IDLE;
               end else begin
                  count_d = count_q + 8'd1;
                  state_d = ST_GET;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Moore output decode from the registered state only, so every output
   // is stable for the whole CPU cycle.
   // ------------------------------------------------------------------
   always_comb begin
      O_ready   = 1'b1;
      O_bus_own = 1'b0;
      O_addr    = 16'h0000;
      O_wr_data = 8'h00;
      O_rdwr    = 1'b1;
      O_busy    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            O_ready = 1'b1;
         end

         ST_HALT, ST_ALIGN: begin
            O_ready = 1'b0;
            O_busy  = 1'b1;
         end

         ST_GET: begin
            O_ready   = 1'b0;
            O_busy    = 1'b1;
            O_bus_own = 1'b1;
            O_addr    = {page_q, count_q};
            O_rdwr    = 1'b1;
         end

         ST_PUT: begin
            O_ready   = 1'b0;
            O_busy    = 1'b1;
            O_bus_own = 1'b1;
            O_addr    = P_OAM_PORT;
            O_wr_data = data_q;
            O_rdwr    = 1'b0;
         end

         default: begin
            O_ready = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
// Module  : tb_oam_dma
// Purpose : Self-checking bench for oam_dma. A transaction-level model
//           expands each trigger into the expected list of per-CPU-cycle
//           bus states (halt, optional align, 256 get/put pairs) and every
//           clock is compared against the head of that list.
// Rev     : 1.0  initial release
// ============================================================================
module tb_oam_dma;

   logic        I_clock = 1'b0;
   logic        I_reset;
   logic        I_cycle;
   logic [15:0] I_cpu_addr;
   logic [7:0]  I_cpu_wr_data;
   logic        I_cpu_rdwr;
   logic [7:0]  I_rd_data;
   logic        O_ready;
   logic        O_bus_own;
   logic [15:0] O_addr;
   logic [7:0]  O_wr_data;
   logic        O_rdwr;
   logic        O_busy;

   oam_dma dut (
      .I_clock       (I_clock),
      .I_reset       (I_reset),
      .I_cycle       (I_cycle),
      .I_cpu_addr    (I_cpu_addr),
      .I_cpu_wr_data (I_cpu_wr_data),
      .I_cpu_rdwr    (I_cpu_rdwr),
      .I_rd_data     (I_rd_data),
      .O_ready       (O_ready),
      .O_bus_own     (O_bus_own),
      .O_addr        (O_addr),
      .O_wr_data     (O_wr_data),
      .O_rdwr        (O_rdwr),
      .O_busy        (O_busy)
   );

   always #5 I_clock = ~I_clock;

   // Observed vector layout: {ready, bus_own, busy, rdwr, addr[15:0], wr_data[7:0]}
   typedef struct packed {
      logic [27:0] v;
      logic [27:0] m;
   } exp_t;

   localparam logic [27:0] M_FULL = 28'hFFF_FFFF;
   localparam logic [27:0] M_CTRL = 28'hF00_0000;
   localparam logic [27:0] M_GET  = 28'hFFF_FF00;

   exp_t        expq[$];
   int          nvec    = 0;
   int          nfail   = 0;
   int          nstrobe = 0;
   int          ncyc    = 0;
   int          halted  = 0;
   logic [7:0]  key_g   = 8'h00;

   function automatic logic [27:0] mkvec(input logic r, input logic o, input logic b,
                                         input logic w, input logic [15:0] a,
                                         input logic [7:0] d);
      return {r, o, b, w, a, d};
   endfunction

   function automatic exp_t mk(input logic [27:0] v, input logic [27:0] m);
      exp_t e;
      e.v = v;
      e.m = m;
      return e;
   endfunction

   // Source memory contents as seen on the shared read bus.
   function automatic logic [7:0] mem_rd(input logic [15:0] a);
      return a[7:0] ^ key_g;
   endfunction

   function automatic exp_t e_idle();
      return mk(mkvec(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00), M_CTRL);
   endfunction

   function automatic exp_t e_reset();
      return mk(mkvec(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00), M_FULL);
   endfunction

   task automatic check(input string tag, input logic [27:0] ev, input logic [27:0] em);
      logic [27:0] obs;
      obs = {O_ready, O_bus_own, O_busy, O_rdwr, O_addr, O_wr_data};
      nvec++;
      assert ((obs & em) === (ev & em)) else begin
         nfail++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h mask=%h", tag, ncyc, obs, ev, em);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int ev);
      nvec++;
      assert (obs === ev) else begin
         nfail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, ev);
      end
   endtask

   // Expand one transfer into the expected sequence of CPU-cycle states.
   task automatic build(input logic [7:0] pg);
      logic in_put_slot;
      in_put_slot = nstrobe[0];
      expq.push_back(mk(mkvec(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00), M_CTRL));
      if (!in_put_slot)
         expq.push_back(mk(mkvec(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00), M_CTRL));
      for (int n = 0; n < 256; n++) begin
         expq.push_back(mk(mkvec(1'b0, 1'b1, 1'b1, 1'b1, {pg, 8'(n)}, 8'h00), M_GET));
         expq.push_back(mk(mkvec(1'b0, 1'b1, 1'b1, 1'b0, 16'h2004,
                                 mem_rd({pg, 8'(n)})), M_FULL));
      end
   endtask

   // One clock: drive inputs, check, advance to the next falling edge.
   task automatic tick(input logic strobe, input exp_t e, input logic [7:0] rd,
                       input string tag);
      I_cycle   = strobe;
      I_rd_data = rd;
      #1;
      check(tag, e.v, e.m);
      @(posedge I_clock);
      @(negedge I_clock);
   endtask

   // One CPU cycle of 3 clocks (plus optional stalled clocks), strobe on last.
   task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                            input int hold);
      exp_t       e;
      logic       busy_now;
      logic       is_get;
      logic [7:0] rd;
      if (expq.size() > 0) begin
         e        = expq.pop_front();
         busy_now = 1'b1;
      end else begin
         e        = e_idle();
         busy_now = 1'b0;
      end
      is_get        = e.v[26] && e.v[24];
      I_cpu_addr    = a;
      I_cpu_wr_data = d;
      I_cpu_rdwr    = rw;
      #1;
      if (!O_ready) halted++;
      for (int i = 0; i < 2 + hold; i++) begin
         rd = is_get ? mem_rd(e.v[23:8]) : 8'($urandom);
         tick(1'b0, e, rd, "cycle");
      end
      rd = is_get ? mem_rd(e.v[23:8]) : 8'($urandom);
      tick(1'b1, e, rd, "strobe");
      nstrobe++;
      ncyc++;
      if (!busy_now && a == 16'h4014 && rw == 1'b0)
         build(d);
   endtask

   task automatic idle_cycle();
      logic [15:0] a;
      a = 16'($urandom);
      if (a == 16'h4014) a = 16'h4015;
      cpu_cycle(a, 8'($urandom), 1'($urandom), 0);
   endtask

   task automatic junk_cycle(input int hold);
      logic [15:0] a;
      a = ($urandom_range(0, 1) == 1) ? 16'h4014 : 16'($urandom);
      cpu_cycle(a, 8'($urandom), 1'b0, hold);
   endtask

   task automatic run_transfer(input logic [7:0] pg, input logic [7:0] k,
                               input logic want_put, input int hold_at);
      int idx;
      key_g = k;
      if (nstrobe[0] == want_put) idle_cycle();
      halted = 0;
      cpu_cycle(16'h4014, pg, 1'b0, 0);
      idx = 0;
      while (expq.size() > 0 && idx < 600) begin
         junk_cycle((idx == hold_at) ? 20 : 0);
         idx++;
      end
      check_int("halt_len", halted, want_put ? 513 : 514);
      cpu_cycle(16'h4015, 8'h00, 1'b0, 0);
   endtask

   initial begin
      logic [7:0] pg;
      I_reset       = 1'b1;
      I_cycle       = 1'b0;
      I_cpu_addr    = 16'h0000;
      I_cpu_wr_data = 8'h00;
      I_cpu_rdwr    = 1'b1;
      I_rd_data     = 8'h00;
      #1 I_reset = 1'b0;
      @(negedge I_clock);
      tick(1'b0, e_reset(), 8'h00, "reset");
      tick(1'b1, e_reset(), 8'h00, "reset");
      I_reset = 1'b1;
      nstrobe = 0;

      // Non-triggering accesses.
      cpu_cycle(16'h4014, 8'h02, 1'b1, 0);
      cpu_cycle(16'h4015, 8'h02, 1'b0, 0);
      for (int i = 0; i < 5; i++) idle_cycle();

      // Page $02, both alignments.
      run_transfer(8'h02, 8'($urandom), 1'b1, -1);
      run_transfer(8'h02, 8'($urandom), 1'b0, -1);

      // Page $FF must not carry into $0000.
      run_transfer(8'hFF, 8'h5A, 1'($urandom), -1);

      // Strobe stalled for 20 clocks mid-transfer.
      run_transfer(8'($urandom), 8'($urandom), 1'($urandom),
                   int'($urandom_range(100, 400)));

      // Reset asserted while reading byte 100.
      key_g = 8'($urandom);
      pg    = 8'($urandom);
      cpu_cycle(16'h4014, pg, 1'b0, 0);
      while (expq.size() > 0 &&
             !(expq[0].m == M_GET && expq[0].v[23:8] == {pg, 8'd100}))
         junk_cycle(0);
      #1;
      check("get100", expq[0].v, expq[0].m);
      #1 I_reset = 1'b0;
      #1;
      check("rst_async", e_reset().v, e_reset().m);
      I_cycle = 1'b1;
      @(posedge I_clock);
      @(negedge I_clock);
      I_cycle = 1'b0;
      #1;
      check("rst_hold", e_reset().v, e_reset().m);
      I_reset = 1'b1;
      expq.delete();
      nstrobe = 0;
      @(negedge I_clock);
      cpu_cycle(16'h4015, 8'h00, 1'b1, 0);

      // Fresh transfer after reset starts from byte 0.
      run_transfer(8'($urandom), 8'($urandom), 1'($urandom), -1);
      for (int i = 0; i < 3; i++) idle_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
